// File: rtl/mem_port_arbiter.sv
// Single-port data memory arbiter between instruction fetch and load/store.
// Optional MEM_ARB_RR_EN selects round-robin priority instead of the starvation-bounded fixed priority.
//
// state    | meaning
// ---------+----------------------------------------------------
// OWN_NONE | no read in flight; rd_data this cycle is unclaimed
// OWN_IF   | fetch read issued last cycle; rd_data goes to fetch
// OWN_LS   | load issued last cycle; rd_data goes to load/store
module mem_port_arbiter #(
    parameter int WIDTH    = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flash_busy,
    input  logic             if_req,
    input  logic [WIDTH-1:0] if_addr,
    output logic             if_gnt,
    output logic             if_rvalid,
    output logic [WIDTH-1:0] if_rdata,
    input  logic             ls_req,
    input  logic             ls_wren,
    input  logic [WIDTH-1:0] ls_addr,
    input  logic [WIDTH-1:0] ls_wdata,
    input  logic [2:0]       ls_funct3,
    output logic             ls_gnt,
    output logic             ls_rvalid,
    output logic [WIDTH-1:0] ls_rdata,
    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_wren,
    output logic [WIDTH-1:0] mem_wr_data,
    output logic [2:0]       mem_funct3,
    input  logic [WIDTH-1:0] mem_rd_data
);

    localparam logic [2:0] FUNCT3_WORD = 3'b010;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_t;

    owner_t owner_q;
    owner_t owner_d;
    logic   if_prio;

`ifdef MEM_ARB_RR_EN
    // Resets to "fetch won last" so load/store takes the first conflict.
    logic last_gnt_ls;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_ls <= 1'b0;
        end else if (if_gnt) begin
            last_gnt_ls <= 1'b0;
        end else if (ls_gnt) begin
            last_gnt_ls <= 1'b1;
        end
    end

    assign if_prio = last_gnt_ls;
`else
    logic [3:0] wait_cnt;

    // Flash takes precedence: the count is frozen while the memory is busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 4'd0;
        end else if (!flash_busy) begin
            if (!if_req || if_gnt) begin
                wait_cnt <= 4'd0;
            end else if (wait_cnt != 4'(MAX_WAIT)) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

    assign if_prio = (wait_cnt == 4'(MAX_WAIT));
`endif

    always_comb begin
        if_gnt      = 1'b0;
        ls_gnt      = 1'b0;
        mem_addr    = '0;
        mem_wren    = 1'b0;
        mem_wr_data = '0;
        mem_funct3  = FUNCT3_WORD;
        if (!flash_busy) begin
            if_gnt = if_req && (!ls_req || if_prio);
            ls_gnt = ls_req && !(if_req && if_prio);
        end
        if (ls_gnt) begin
            mem_addr    = ls_addr;
            mem_wren    = ls_wren;
            mem_wr_data = ls_wdata;
            mem_funct3  = ls_funct3;
        end else if (if_gnt) begin
            mem_addr    = if_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    always_comb begin
        owner_d = OWN_NONE;
        if (if_gnt) begin
            owner_d = OWN_IF;
        end else if (ls_gnt && !ls_wren) begin
            owner_d = OWN_LS;
        end
    end

    assign if_rvalid = (owner_q == OWN_IF);
    assign ls_rvalid = (owner_q == OWN_LS);
    assign if_rdata  = mem_rd_data;
    assign ls_rdata  = mem_rd_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run against a cycle-level reference model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int WIDTH = 32;
    localparam int MAX_WAIT = 4;
    localparam logic [2:0] WORD = 3'b010;

    logic             clk;
    logic             rst;
    logic             flash_busy;
    logic             if_req;
    logic [WIDTH-1:0] if_addr;
    logic             if_gnt;
    logic             if_rvalid;
    logic [WIDTH-1:0] if_rdata;
    logic             ls_req;
    logic             ls_wren;
    logic [WIDTH-1:0] ls_addr;
    logic [WIDTH-1:0] ls_wdata;
    logic [2:0]       ls_funct3;
    logic             ls_gnt;
    logic             ls_rvalid;
    logic [WIDTH-1:0] ls_rdata;
    logic [WIDTH-1:0] mem_addr;
    logic             mem_wren;
    logic [WIDTH-1:0] mem_wr_data;
    logic [2:0]       mem_funct3;
    logic [WIDTH-1:0] mem_rd_data;

    int total = 0;
    int bad = 0;

    mem_port_arbiter #(.WIDTH(WIDTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .flash_busy(flash_busy),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_wren(ls_wren), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_funct3(ls_funct3), .ls_gnt(ls_gnt),
        .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wr_data(mem_wr_data),
        .mem_funct3(mem_funct3), .mem_rd_data(mem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flash_busy = 1'b0;
        if_req = 1'b0;
        if_addr = '0;
        ls_req = 1'b0;
        ls_wren = 1'b0;
        ls_addr = '0;
        ls_wdata = '0;
        ls_funct3 = WORD;
        mem_rd_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        #1;
        if ({if_rvalid, ls_rvalid} !== 2'b00) begin
            bad++;
            $display("FAIL reset_rvalid got=%b exp=00", {if_rvalid, ls_rvalid});
        end
        total++;
        rst = 1'b0;
        #1;
        if ({if_gnt, ls_gnt} !== 2'b00) begin
            bad++;
            $display("FAIL reset_gnt got=%b exp=00", {if_gnt, ls_gnt});
        end
        total++;
        if ({mem_addr, mem_wren, mem_wr_data, mem_funct3} !== {32'h0, 1'b0, 32'h0, WORD}) begin
            bad++;
            $display("FAIL reset_mem addr=%h wren=%b wd=%h f3=%b exp 0/0/0/%b",
                     mem_addr, mem_wren, mem_wr_data, mem_funct3, WORD);
        end
        total++;
        tick();
        if ({if_rvalid, ls_rvalid} !== 2'b00) begin
            bad++;
            $display("FAIL idle_rvalid got=%b exp=00", {if_rvalid, ls_rvalid});
        end
        total++;
    endtask

    task automatic test_fetch_single();
        if_req = 1'b1;
        if_addr = 32'h10;
        #1;
        if ({if_gnt, ls_gnt} !== 2'b10) begin
            bad++;
            $display("FAIL fetch_gnt got=%b exp=10", {if_gnt, ls_gnt});
        end
        total++;
        if ({mem_addr, mem_wren, mem_wr_data, mem_funct3} !== {32'h10, 1'b0, 32'h0, WORD}) begin
            bad++;
            $display("FAIL fetch_mem addr=%h wren=%b wd=%h f3=%b exp 10/0/0/%b",
                     mem_addr, mem_wren, mem_wr_data, mem_funct3, WORD);
        end
        total++;
        tick();
        if_req = 1'b0;
        mem_rd_data = 32'hCAFE0010;
        #1;
        if ({if_rvalid, ls_rvalid} !== 2'b10) begin
            bad++;
            $display("FAIL fetch_rvalid got=%b exp=10", {if_rvalid, ls_rvalid});
        end
        total++;
        if (if_rdata !== 32'hCAFE0010) begin
            bad++;
            $display("FAIL fetch_rdata got=%h exp=cafe0010", if_rdata);
        end
        total++;
        tick();
        if (if_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL fetch_rvalid_once got=%b exp=0", if_rvalid);
        end
        total++;
    endtask

    task automatic test_store();
        ls_req = 1'b1;
        ls_wren = 1'b1;
        ls_addr = 32'h20;
        ls_wdata = 32'hDEADBEEF;
        ls_funct3 = 3'b001;
        #1;
        if ({if_gnt, ls_gnt} !== 2'b01) begin
            bad++;
            $display("FAIL store_gnt got=%b exp=01", {if_gnt, ls_gnt});
        end
        total++;
        if ({mem_addr, mem_wren, mem_wr_data, mem_funct3} !== {32'h20, 1'b1, 32'hDEADBEEF, 3'b001}) begin
            bad++;
            $display("FAIL store_mem addr=%h wren=%b wd=%h f3=%b exp 20/1/deadbeef/001",
                     mem_addr, mem_wren, mem_wr_data, mem_funct3);
        end
        total++;
        tick();
        ls_req = 1'b0;
        ls_wren = 1'b0;
        #1;
        if ({if_rvalid, ls_rvalid} !== 2'b00) begin
            bad++;
            $display("FAIL store_no_rvalid got=%b exp=00", {if_rvalid, ls_rvalid});
        end
        total++;
    endtask

    // Both loads held high: expected winner per cycle follows directly from the priority scheme.
    task automatic test_priority();
        int prev;
        bit exp_ls;
        do_reset();
        if_req = 1'b1;
        if_addr = 32'h100;
        ls_req = 1'b1;
        ls_wren = 1'b0;
        ls_addr = 32'h200;
        ls_funct3 = WORD;
        prev = 0;
        for (int k = 0; k < 16; k++) begin
            mem_rd_data = $urandom;
            #1;
            if ({if_rvalid, ls_rvalid} !== {prev == 1, prev == 2}) begin
                bad++;
                $display("FAIL prio_rvalid k=%0d got=%b exp=%b", k, {if_rvalid, ls_rvalid},
                         {prev == 1, prev == 2});
            end
            total++;
`ifdef MEM_ARB_RR_EN
            exp_ls = (k % 2) == 0;
`else
            exp_ls = (k % (MAX_WAIT + 1)) != MAX_WAIT;
`endif
            if ({if_gnt, ls_gnt} !== {!exp_ls, exp_ls}) begin
                bad++;
                $display("FAIL prio_gnt k=%0d got=%b exp=%b", k, {if_gnt, ls_gnt}, {!exp_ls, exp_ls});
            end
            total++;
            if (mem_addr !== (exp_ls ? 32'h200 : 32'h100)) begin
                bad++;
                $display("FAIL prio_addr k=%0d got=%h exp=%h", k, mem_addr, exp_ls ? 32'h200 : 32'h100);
            end
            total++;
            prev = exp_ls ? 2 : 1;
            tick();
        end
        idle_inputs();
        #1;
        if ({if_rvalid, ls_rvalid} !== {prev == 1, prev == 2}) begin
            bad++;
            $display("FAIL prio_last_rvalid got=%b exp=%b", {if_rvalid, ls_rvalid}, {prev == 1, prev == 2});
        end
        total++;
        tick();
    endtask

    // Two grants, five flash cycles, three grants: post-flash order shows the priority state was frozen.
    task automatic test_flash();
        bit exp_seq[5];
        bit exp_ls;
`ifdef MEM_ARB_RR_EN
        exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
        do_reset();
        if_req = 1'b1;
        if_addr = 32'h300;
        ls_req = 1'b1;
        ls_wren = 1'b1;
        ls_addr = 32'h400;
        ls_wdata = 32'h12345678;
        for (int k = 0; k < 10; k++) begin
            flash_busy = (k >= 2 && k < 7);
            #1;
            if (flash_busy) begin
                if ({if_gnt, ls_gnt, mem_wren} !== 3'b000) begin
                    bad++;
                    $display("FAIL flash_block k=%0d gnt/wren got=%b exp=000", k, {if_gnt, ls_gnt, mem_wren});
                end
                total++;
            end else begin
                exp_ls = exp_seq[(k < 2) ? k : k - 5];
                if ({if_gnt, ls_gnt, mem_wren} !== {!exp_ls, exp_ls, exp_ls}) begin
                    bad++;
                    $display("FAIL flash_gnt k=%0d gnt/wren got=%b exp=%b", k, {if_gnt, ls_gnt, mem_wren},
                             {!exp_ls, exp_ls, exp_ls});
                end
                total++;
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_flash_inflight();
        do_reset();
        ls_req = 1'b1;
        ls_wren = 1'b0;
        ls_addr = 32'h40;
        #1;
        if (ls_gnt !== 1'b1) begin
            bad++;
            $display("FAIL inflight_gnt got=%b exp=1", ls_gnt);
        end
        total++;
        tick();
        ls_req = 1'b0;
        flash_busy = 1'b1;
        mem_rd_data = 32'h00005A5A;
        #1;
        if ({ls_rvalid, ls_rdata} !== {1'b1, 32'h00005A5A}) begin
            bad++;
            $display("FAIL inflight_rvalid got=%b/%h exp=1/00005a5a", ls_rvalid, ls_rdata);
        end
        total++;
        tick();
        if (ls_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL inflight_once got=%b exp=0", ls_rvalid);
        end
        total++;
        idle_inputs();
    endtask

    task automatic test_reset_midread();
        do_reset();
        if_req = 1'b1;
        if_addr = 32'h80;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if_req = 1'b0;
        #1;
        if (if_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL midread_drop got=%b exp=0", if_rvalid);
        end
        total++;
        tick();
    endtask

    task automatic test_random();
        int denials;
        bit last_ls;
        int pend;
        bit gi;
        bit gl;
        bit gi_prev;
        bit gl_prev;
        bit both;
        logic [67:0] exp_bus;
        do_reset();
        denials = 0;
        last_ls = 1'b0;
        pend = 0;
        gi_prev = 1'b0;
        gl_prev = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (gi_prev) if_req = 1'b0;
            if (gl_prev) ls_req = 1'b0;
            flash_busy = ($urandom_range(0, 7) == 0);
            if (!if_req) begin
                if ($urandom_range(0, 1) == 1) begin
                    if_req = 1'b1;
                    if_addr = $urandom;
                end
            end else if ($urandom_range(0, 9) == 0) begin
                if_req = 1'b0;
            end
            if (!ls_req) begin
                if ($urandom_range(0, 1) == 1) begin
                    ls_req = 1'b1;
                    ls_wren = 1'($urandom_range(0, 1));
                    ls_addr = $urandom;
                    ls_wdata = $urandom;
                    ls_funct3 = 3'($urandom_range(0, 7));
                end
            end else if ($urandom_range(0, 9) == 0) begin
                ls_req = 1'b0;
            end
            mem_rd_data = $urandom;
            #1;
            if ({if_rvalid, ls_rvalid} !== {pend == 1, pend == 2}) begin
                bad++;
                $display("FAIL rand_rvalid n=%0d got=%b exp=%b", n, {if_rvalid, ls_rvalid}, {pend == 1, pend == 2});
            end
            total++;
            if ((pend == 1 && if_rdata !== mem_rd_data) || (pend == 2 && ls_rdata !== mem_rd_data)) begin
                bad++;
                $display("FAIL rand_rdata n=%0d got=%h/%h exp=%h", n, if_rdata, ls_rdata, mem_rd_data);
            end
            total++;
            both = if_req && ls_req;
            if (flash_busy) begin
                gi = 1'b0;
                gl = 1'b0;
            end else if (!both) begin
                gi = if_req;
                gl = ls_req;
            end else begin
`ifdef MEM_ARB_RR_EN
                gi = last_ls;
`else
                gi = (denials == MAX_WAIT);
`endif
                gl = !gi;
            end
            if (gl) exp_bus = {ls_addr, ls_wren, ls_wdata, ls_funct3};
            else if (gi) exp_bus = {if_addr, 1'b0, 32'h0, WORD};
            else exp_bus = {32'h0, 1'b0, 32'h0, WORD};
            if ({if_gnt, ls_gnt} !== {gi, gl}) begin
                bad++;
                $display("FAIL rand_gnt n=%0d got=%b exp=%b", n, {if_gnt, ls_gnt}, {gi, gl});
            end
            total++;
            if ({mem_addr, mem_wren, mem_wr_data, mem_funct3} !== exp_bus) begin
                bad++;
                $display("FAIL rand_mem n=%0d got=%h exp=%h", n,
                         {mem_addr, mem_wren, mem_wr_data, mem_funct3}, exp_bus);
            end
            total++;
            pend = gi ? 1 : ((gl && !ls_wren) ? 2 : 0);
            if (!flash_busy) begin
                if (!if_req || gi) denials = 0;
                else if (denials < MAX_WAIT) denials++;
            end
            if (gi) last_ls = 1'b0;
            else if (gl) last_ls = 1'b1;
            gi_prev = gi;
            gl_prev = gl;
            tick();
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_fetch_single();
        test_store();
        test_priority();
        test_flash();
        test_flash_inflight();
        test_reset_midread();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-port data memory between the instruction-fetch unit and the load/store unit, granting at most one access per cycle. Drives the memory's addr/wren/wr_data/funct3 inputs and routes the one-cycle-latency rd_data back to the owner of each read. Fixed load/store priority is bounded by an anti-starvation counter for fetch. All new grants are held off while the memory is being flashed.

Parameters:
WIDTH, 32, address/data width
MAX_WAIT, 4, consecutive fetch denials after which fetch gets priority for one grant (1..15)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
flash_busy  in  1  memory flash in progress; blocks new grants
if_req  in  1  fetch request; held with stable if_addr until if_gnt
if_addr  in  WIDTH  fetch address
if_gnt  out  1  fetch accepted this cycle (combinational)
if_rvalid  out  1  if_rdata valid (registered)
if_rdata  out  WIDTH  fetch data
ls_req  in  1  load/store request; held with stable fields until ls_gnt
ls_wren  in  1  0 = load, 1 = store
ls_addr  in  WIDTH  load/store address
ls_wdata  in  WIDTH  store data
ls_funct3  in  3  access size, passed through
ls_gnt  out  1  load/store accepted this cycle (combinational)
ls_rvalid  out  1  ls_rdata valid (registered); loads only
ls_rdata  out  WIDTH  load data
mem_addr  out  WIDTH  to memory addr
mem_wren  out  1  to memory wren
mem_wr_data  out  WIDTH  to memory wr_data
mem_funct3  out  3  to memory funct3 (WORD for fetch)
mem_rd_data  in  WIDTH  from memory rd_data, valid one cycle after address

Behaviour:
- Reset: if_rvalid=0, ls_rvalid=0, owner=NONE, wait_cnt=0. Combinational outputs follow from inputs and state; with no request, mem_wren=0, mem_addr=0, mem_wr_data=0, mem_funct3=WORD.
- Grant rule, per cycle: no grant if flash_busy=1. Otherwise, if only one requester is active, grant it. If both are active, grant ls unless wait_cnt==MAX_WAIT, in which case grant if. At most one of if_gnt/ls_gnt is high.
- mem_* driven combinationally from the granted requester in the grant cycle. mem_wren = ls_gnt & ls_wren; a fetch never writes.
- Owner register: next owner = IF on if_gnt, LS on ls_gnt & !ls_wren, else NONE.
- Read return: if_rvalid = (owner==IF); ls_rvalid = (owner==LS). Both rdata outputs are mem_rd_data. Latency is exactly 1 cycle after grant, and back-to-back grants give back-to-back rvalids. Stores produce no rvalid.
- wait_cnt tracking:
  - Increments when if_req=1 without if_gnt and flash_busy=0.
  - Clears on if_gnt, or whenever if_req=0.
  - Saturates at MAX_WAIT.
  - Holds while flash_busy=1.
- flash_busy rising with a read in flight: the pending rvalid is still delivered next cycle. Data coherence during flash is not guaranteed.
- Reset mid-read: the pending rvalid is dropped. Requesters must reissue.
- Requester drops req before grant: permitted, no side effects.

Optional Feature:
MEM_ARB_RR_EN:
- Defined: MAX_WAIT and wait_cnt are unused, and priority is round-robin. A last_gnt flop (reset = IF, so ls wins the first conflict) records the most recent winner; on conflict the other requester wins.
- Undefined: fixed ls priority with the MAX_WAIT starvation bound as above.

Test Plan:
- Reset, then if_req=1, if_addr=0x10 alone: if_gnt=1 the same cycle, mem_addr=0x10, mem_wren=0. Next cycle if_rvalid=1 and if_rdata=mem_rd_data; ls_rvalid stays 0.
- ls_req=1, ls_wren=1, addr=0x20, wdata=0xDEADBEEF: ls_gnt=1, mem_wren=1, mem_wr_data=0xDEADBEEF. Following cycle ls_rvalid=0.
- if_req and ls_req (loads) held high continuously, MAX_WAIT=4: grants are ls×4, if×1, repeating. Each rvalid is seen one cycle after its matching grant.
- flash_busy=1 for 5 cycles with both requests high: no grants and mem_wren=0. wait_cnt unchanged. Grants resume the cycle flash_busy falls.
- Load granted, flash_busy=1 the next cycle: ls_rvalid=1 still asserts exactly once. rst=1 asserted the cycle after a fetch grant: if_rvalid=0.
- With MEM_ARB_RR_EN defined and both requesting continuously: grants alternate ls, if, ls, if starting with ls.
